eth_mdio_ctrl: RTL and testbench

ETH_MDIO_CTRL -- requirements
Module: eth_mdio_ctrl

---
 rtl/eth_pkg.sv | 24 ++
 rtl/eth_mdc_gen.sv | 50 +++++
 rtl/eth_mdio_ctrl.sv | 160 ++++++++++++++++
 tb/tb_eth_mdio_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the MDIO management controller: opcodes, frame
// field lengths, default register addresses and the frame FSM state type.
package eth_pkg;

    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    localparam logic [7:0] DEF_CMD_ADDR  = 8'h40;
    localparam logic [7:0] DEF_STAT_ADDR = 8'h41;

    localparam int unsigned HDR_BITS  = 14;
    localparam int unsigned TA_BITS   = 2;
    localparam int unsigned DATA_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_TA,
        ST_DATA,
        ST_DONE
    } mdio_state_e;

endpackage

// File: rtl/eth_mdc_gen.sv
// MDC generator: free-runs only while enabled, starting low, and emits
// single-cycle strobes on the clock edge where MDC rises or falls.
module eth_mdc_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic i_clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_mdc,
    output logic o_mdc_rise,
    output logic o_mdc_fall
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             mdc_q, mdc_d;
    logic             wrap;

    assign wrap = i_en && (cnt_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!i_en) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            mdc_d = ~mdc_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    assign o_mdc      = mdc_q;
    assign o_mdc_rise = wrap && !mdc_q;
    assign o_mdc_fall = wrap && mdc_q;

endmodule

// File: rtl/eth_mdio_ctrl.sv
// MDIO (clause 22) management frame controller with a register-style command
// port, sticky overrun flag and completion interrupt pulse.
module eth_mdio_ctrl
    import eth_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 25,
    parameter int unsigned PRE_LEN   = 32,
    parameter logic [7:0]  CMD_ADDR  = DEF_CMD_ADDR,
    parameter logic [7:0]  STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic        i_cmd_wr,
    input  logic [7:0]  i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    output logic [15:0] o_rd_data,
    output logic        o_busy,
    output logic        o_irq_done,
    output logic        o_overrun,
    output logic        o_mdc,
    output logic        o_mdio_out,
    output logic        o_mdio_oe,
    input  logic        i_mdio_in
);

    localparam int unsigned CNT_MAX  = (PRE_LEN > DATA_BITS) ? PRE_LEN : DATA_BITS;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);
    localparam int unsigned PRE_LAST = (PRE_LEN == 0) ? 0 : PRE_LEN - 1;

    mdio_state_e      state_q, state_d;
    mdio_state_e      next_field;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] last_idx;
    logic [31:0]      sh_q, sh_d;
    logic [15:0]      rd_sh_q, rd_sh_d;
    logic [15:0]      rd_data_q, rd_data_d;
    logic             op_rd_q, op_rd_d;
    logic             ovr_q, ovr_d;

    logic       busy, mdc_rise, mdc_fall;
    logic [1:0] cmd_op;
    logic       cmd_valid, accept, stat_clr, last_bit;
    logic [3:0] unused_cmd_hi;

    assign cmd_op        = i_cmd_data[27:26];
    assign unused_cmd_hi = i_cmd_data[31:28];
    assign cmd_valid     = i_cmd_wr && (i_cmd_addr == CMD_ADDR) &&
                           (cmd_op == MDIO_OP_WR || cmd_op == MDIO_OP_RD);
    assign busy          = state_q inside {ST_PRE, ST_HDR, ST_TA, ST_DATA};
    assign accept        = cmd_valid && !busy;
    assign stat_clr      = i_cmd_wr && (i_cmd_addr == STAT_ADDR);

    eth_mdc_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_mdc_gen (
        .i_clk      (i_clk),
        .rst_n      (rst_n),
        .i_en       (busy),
        .o_mdc      (o_mdc),
        .o_mdc_rise (mdc_rise),
        .o_mdc_fall (mdc_fall)
    );

    always_comb begin
        last_idx   = '0;
        next_field = ST_IDLE;
        case (state_q)
            ST_PRE: begin
                last_idx   = CNT_W'(PRE_LAST);
                next_field = ST_HDR;
            end
            ST_HDR: begin
                last_idx   = CNT_W'(HDR_BITS - 1);
                next_field = ST_TA;
            end
            ST_TA: begin
                last_idx   = CNT_W'(TA_BITS - 1);
                next_field = ST_DATA;
            end
            ST_DATA: begin
                last_idx   = CNT_W'(DATA_BITS - 1);
                next_field = ST_DONE;
            end
            default: ;
        endcase
    end

    assign last_bit = (bit_cnt_q == last_idx);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        rd_sh_d   = rd_sh_q;
        rd_data_d = rd_data_q;
        op_rd_d   = op_rd_q;
        ovr_d     = ovr_q;

        if (stat_clr) ovr_d = 1'b0;
        if (cmd_valid && busy) ovr_d = 1'b1;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d   = (PRE_LEN == 0) ? ST_HDR : ST_PRE;
                    bit_cnt_d = '0;
                    op_rd_d   = (cmd_op == MDIO_OP_RD);
                    // Reads keep ones in the TA/DATA slots; the pad is released there anyway.
                    sh_d = {2'b01, cmd_op, i_cmd_data[25:16],
                            (cmd_op == MDIO_OP_RD) ? 18'h3FFFF : {2'b10, i_cmd_data[15:0]}};
                end
            end
            default: begin
                if (mdc_rise && state_q == ST_DATA) begin
                    rd_sh_d = {rd_sh_q[14:0], i_mdio_in};
                end
                if (mdc_fall) begin
                    if (state_q != ST_PRE) sh_d = {sh_q[30:0], 1'b1};
                    if (last_bit) begin
                        bit_cnt_d = '0;
                        state_d   = next_field;
                        if (next_field == ST_DONE && op_rd_q) rd_data_d = rd_sh_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '1;
            rd_sh_q   <= '0;
            rd_data_q <= '0;
            op_rd_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            rd_sh_q   <= rd_sh_d;
            rd_data_q <= rd_data_d;
            op_rd_q   <= op_rd_d;
            ovr_q     <= ovr_d;
        end
    end

    assign o_busy     = busy;
    assign o_irq_done = (state_q == ST_DONE);
    assign o_overrun  = ovr_q;
    assign o_rd_data  = rd_data_q;
    assign o_mdio_out = (state_q inside {ST_HDR, ST_TA, ST_DATA}) ? sh_q[31] : 1'b1;
    assign o_mdio_oe  = (state_q inside {ST_PRE, ST_HDR}) ||
                        ((state_q inside {ST_TA, ST_DATA}) && !op_rd_q);

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Scoreboard bench for eth_mdio_ctrl: stimulus pushes expected frames derived
// from the MDIO frame format; a monitor captures frames at MDC rises and compares.
module tb_eth_mdio_ctrl;
    import eth_pkg::*;

    localparam int unsigned DIV       = 4;
    localparam int unsigned PRE       = 32;
    localparam int unsigned FRAME_CYC = (PRE + 32) * 2 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        mdio_in = 1'b1;
    logic [15:0] o_rd_data;
    logic        o_busy, o_irq_done, o_overrun, o_mdc, o_mdio_out, o_mdio_oe;

    logic        cmd0_wr = 1'b0;
    logic [7:0]  cmd0_addr = '0;
    logic [31:0] cmd0_data = '0;
    logic        busy0, irq0, mdc0, out0;
    logic [15:0] unused_rd0;
    logic        unused_ovr0, unused_oe0;

    always #5 clk = ~clk;

    eth_mdio_ctrl #(.CLK_DIV(DIV), .PRE_LEN(PRE), .CMD_ADDR(8'h40), .STAT_ADDR(8'h41)) dut (
        .i_clk(clk), .rst_n(rst_n), .i_cmd_wr(cmd_wr), .i_cmd_addr(cmd_addr),
        .i_cmd_data(cmd_data), .o_rd_data(o_rd_data), .o_busy(o_busy),
        .o_irq_done(o_irq_done), .o_overrun(o_overrun), .o_mdc(o_mdc),
        .o_mdio_out(o_mdio_out), .o_mdio_oe(o_mdio_oe), .i_mdio_in(mdio_in)
    );

    eth_mdio_ctrl #(.CLK_DIV(DIV), .PRE_LEN(0), .CMD_ADDR(8'h40), .STAT_ADDR(8'h41)) dut0 (
        .i_clk(clk), .rst_n(rst_n), .i_cmd_wr(cmd0_wr), .i_cmd_addr(cmd0_addr),
        .i_cmd_data(cmd0_data), .o_rd_data(unused_rd0), .o_busy(busy0),
        .o_irq_done(irq0), .o_overrun(unused_ovr0), .o_mdc(mdc0),
        .o_mdio_out(out0), .o_mdio_oe(unused_oe0), .i_mdio_in(1'b1)
    );

    typedef struct {
        logic [63:0] bits;
        logic [63:0] mask;
        int unsigned nbits;
        int unsigned dur;
        logic [15:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int          irq_seen = 0;
    int          frames_exp = 0;
    logic [15:0] phy_val = '0;
    logic [15:0] last_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: a frame is PRE ones, then ST/OP/PHYAD/REGAD, then TA + data.
    function automatic exp_t model(input logic [1:0] op, input logic [4:0] phy,
                                   input logic [4:0] ra, input logic [15:0] wdata,
                                   input logic [15:0] rval, input logic [15:0] prev_rd);
        exp_t        e;
        logic        is_rd;
        logic [31:0] body, bmask;
        is_rd   = (op == 2'b10);
        body    = {2'b01, op, phy, ra, is_rd ? 18'h0 : {2'b10, wdata}};
        bmask   = is_rd ? 32'hFFFC_0000 : 32'hFFFF_FFFF;
        e.bits  = {32'hFFFF_FFFF, body};
        e.mask  = {32'hFFFF_FFFF, bmask};
        e.nbits = PRE + 32;
        e.dur   = FRAME_CYC;
        e.rd    = is_rd ? rval : prev_rd;
        return e;
    endfunction

    initial begin : monitor
        logic        pb, pm, po, in_frame;
        logic [63:0] cap, capoe;
        int unsigned nb, cyc, viol;
        exp_t        e;
        pb = 1'b0; pm = 1'b0; po = 1'b1; in_frame = 1'b0;
        cap = '0; capoe = '0; nb = 0; cyc = 0; viol = 0;
        forever begin
            @(negedge clk);
            if (o_busy && !pb) begin
                in_frame = 1'b1; cap = '0; capoe = '0; nb = 0; cyc = 0; viol = 0;
            end
            if (in_frame) begin
                if (o_busy) cyc++;
                if (o_mdc && !pm) begin
                    cap   = {cap[62:0], o_mdio_out};
                    capoe = {capoe[62:0], o_mdio_oe};
                    nb++;
                end
                if ((o_busy || o_irq_done) && (o_mdio_out !== po) &&
                    !(pm && !o_mdc) && !(o_busy && !pb)) viol++;
            end
            if (o_irq_done) begin
                irq_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_irq: got pulse expected none");
                end else begin
                    e = sb.pop_front();
                    chk("frame_nbits", 64'(nb), 64'(e.nbits));
                    chk("frame_bits", cap & e.mask, e.bits & e.mask);
                    chk("frame_oe", capoe, e.mask);
                    chk("busy_cycles", 64'(cyc), 64'(e.dur));
                    chk("rd_data_at_done", 64'(o_rd_data), 64'(e.rd));
                    chk("done_mdc_oe", {62'(0), o_mdc, o_mdio_oe}, 64'(0));
                    chk("mdio_change_only_on_fall", 64'(viol), 64'(0));
                end
                in_frame = 1'b0;
            end else if (!o_busy) begin
                in_frame = 1'b0;
            end
            pb = o_busy; pm = o_mdc; po = o_mdio_out;
        end
    end

    // PHY: drives read data for bits 48..63, changing after MDC falls.
    initial begin : phy
        logic pb, pm;
        int   j;
        pb = 1'b0; pm = 1'b0; j = 0;
        forever begin
            @(negedge clk);
            if (o_busy && !pb) j = 0;
            else if (pm && !o_mdc) j++;
            mdio_in = (j >= 48 && j < 64) ? phy_val[63 - j] : 1'b1;
            pb = o_busy; pm = o_mdc;
        end
    end

    task automatic issue(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        cmd_wr = 1'b1; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        cmd_wr = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                        input logic [15:0] wdata, input logic [15:0] rval);
        exp_t e;
        e = model(op, phy, ra, wdata, rval, last_rd);
        if (op == 2'b10) last_rd = rval;
        phy_val = rval;
        sb.push_back(e);
        frames_exp++;
        issue(8'h40, {4'h0, op, phy, ra, wdata});
        chk("busy_rise", 64'(o_busy), 64'(1));
    endtask

    task automatic wait_done();
        int unsigned n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (o_irq_done) break;
            n++;
        end
        chk("done_within_budget", 64'(n < 3000), 64'(1));
    endtask

    initial begin : stim
        logic        bad;
        logic [1:0]  op;
        logic [63:0] cap;
        int unsigned cyc, nb, n;
        logic        pm;
        exp_t        e;

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_irq", 64'(o_irq_done), 64'(0));
        chk("rst_overrun", 64'(o_overrun), 64'(0));
        chk("rst_rd_data", 64'(o_rd_data), 64'(0));
        chk("rst_mdc", 64'(o_mdc), 64'(0));
        chk("rst_oe", 64'(o_mdio_oe), 64'(0));
        chk("rst_mdio_out", 64'(o_mdio_out), 64'(1));
        rst_n = 1'b1;

        send(2'b01, 5'd1, 5'd0, 16'h1140, 16'h0);
        wait_done();
        send(2'b10, 5'd1, 5'd2, 16'h0000, 16'h0141);
        wait_done();

        issue(8'h40, 32'h0C22_0000);
        issue(8'h42, 32'h0420_1140);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (o_busy || o_mdc || o_mdio_oe) bad = 1'b1;
        end
        chk("ignored_cmd_idle", 64'(bad), 64'(0));
        chk("ignored_no_overrun", 64'(o_overrun), 64'(0));

        send(2'b01, 5'd1, 5'd0, 16'h1140, 16'h0);
        repeat (97) @(negedge clk);
        issue(8'h40, 32'h0022_0000);
        chk("op00_busy_no_overrun", 64'(o_overrun), 64'(0));
        issue(8'h40, 32'h07FF_A5A5);
        chk("overrun_set", 64'(o_overrun), 64'(1));
        wait_done();
        chk("overrun_sticky", 64'(o_overrun), 64'(1));
        issue(8'h41, 32'h0);
        chk("overrun_cleared", 64'(o_overrun), 64'(0));

        for (int i = 0; i < 10; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            send(op, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
            wait_done();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        send(2'b10, 5'd3, 5'd4, 16'h0, 16'hBEEF);
        wait_done();
        send(2'b01, 5'd1, 5'd0, 16'h1140, 16'h0);
        repeat (322) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        frames_exp--;
        @(negedge clk);
        chk("abort_mdc", 64'(o_mdc), 64'(0));
        chk("abort_oe", 64'(o_mdio_oe), 64'(0));
        chk("abort_busy", 64'(o_busy), 64'(0));
        chk("abort_irq", 64'(o_irq_done), 64'(0));
        chk("abort_rd_data", 64'(o_rd_data), 64'(0));
        last_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b01, 5'd1, 5'd0, 16'h1140, 16'h0);
        wait_done();

        e = model(2'b01, 5'd1, 5'd0, 16'h1140, 16'h0, 16'h0);
        @(negedge clk);
        cmd0_wr = 1'b1; cmd0_addr = 8'h40; cmd0_data = 32'h0420_1140;
        @(negedge clk);
        cmd0_wr = 1'b0;
        chk("pre0_busy_rise", 64'(busy0), 64'(1));
        cap = '0; cyc = 0; nb = 0; n = 0; pm = 1'b0;
        while (n < 1000) begin
            if (busy0) cyc++;
            if (mdc0 && !pm) begin
                cap = {cap[62:0], out0};
                nb++;
            end
            if (irq0) break;
            pm = mdc0;
            @(negedge clk);
            n++;
        end
        chk("pre0_done_within_budget", 64'(n < 1000), 64'(1));
        chk("pre0_nbits", 64'(nb), 64'(32));
        chk("pre0_bits", cap, {32'h0, e.bits[31:0]});
        chk("pre0_busy_cycles", 64'(cyc), 64'(32 * 2 * DIV));

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("irq_count", 64'(irq_seen), 64'(frames_exp));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
